// File: rtl/utopia_rx_cell_source.sv
// utopia_rx_cell_source: PHY-side UTOPIA L1 Rx cell transmitter with a CELLS x 53-byte cell buffer.
// Latency: a cell committed on edge N presents octet 0 (soc=1) on edge N+1; a cell takes 53 edges with en=0.
// Backpressure: in_ready drops while every slot is committed or in transmission; en=1 holds the octet.
// Build option: define UTOPIA_RX_HEC_GEN_EN to replace octet 4 with a CRC-8 HEC (XOR 8'h55) of octets 0-3.
module utopia_rx_cell_source #(
  parameter int CELLS      = 2,
  parameter int CELL_BYTES = 53
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_sop,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       err_drop,
  output logic [7:0] data,
  output logic       soc,
  output logic       clav,
  input  logic       en
);

  localparam int            SW        = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int            CW        = $clog2(CELLS + 1);
  localparam logic [5:0]    LAST_OFF  = 6'(CELL_BYTES - 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(CELLS - 1);
  localparam logic [CW:0]   CELLS_W   = (CW + 1)'(CELLS);

  typedef enum logic {LD_IDLE, LD_FILL} ld_state_t;
  typedef enum logic {SD_IDLE, SD_SEND} sd_state_t;

  ld_state_t     ld_state;
  sd_state_t     sd_state;
  logic [SW-1:0] wr_slot;
  logic [SW-1:0] rd_slot;
  logic [SW-1:0] rd_next;
  logic [5:0]    wr_off;
  logic [5:0]    rd_off;
  logic [5:0]    wr_idx;
  logic [7:0]    wr_byte;
  logic [CW-1:0] full_cnt;
  logic [CW-1:0] cnt_next;
  logic [CW:0]   occupied;
  logic          busy;
  logic          consume;
  logic          last_take;
  logic          start;
  logic          ld_fire;
  logic          wr_en;
  logic          commit;

  logic [7:0] mem [CELLS][CELL_BYTES];

  function automatic logic [SW-1:0] next_slot(input logic [SW-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + 1'b1;
  endfunction

  assign busy      = (sd_state == SD_SEND);
  assign consume   = busy && !en;
  assign last_take = consume && (rd_off == LAST_OFF);
  assign start     = ((sd_state == SD_IDLE) || last_take) && (full_cnt != '0);
  assign rd_next   = next_slot(rd_slot);

  // Slots in use: committed cells plus the one on the wire, minus a slot released on this edge,
  // so a new load can begin on the very edge that frees a slot.
  always_comb begin
    occupied = {1'b0, full_cnt} + {{CW{1'b0}}, busy} - {{CW{1'b0}}, last_take};
  end

  assign in_ready = (occupied < CELLS_W);
  assign ld_fire  = in_valid && in_ready;
  assign wr_en    = ld_fire && (in_sop || (ld_state == LD_FILL));
  assign wr_idx   = in_sop ? 6'd0 : wr_off;
  assign commit   = ld_fire && !in_sop && (ld_state == LD_FILL) && (wr_off == LAST_OFF);

`ifdef UTOPIA_RX_HEC_GEN_EN
  logic [7:0] crc;

  // One CRC-8 step, generator x^8+x^2+x+1, MSB of the octet first.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[7] ^ d[i]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  assign wr_byte = (wr_idx == 6'd4) ? (crc ^ 8'h55) : in_data;

  // Running header CRC: reseeded by every start-of-cell byte, accumulates octets 1..3.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= 8'h00;
    end else if (wr_en) begin
      if (in_sop) begin
        crc <= crc8_step(8'h00, in_data);
      end else if (wr_off < 6'd4) begin
        crc <= crc8_step(crc, in_data);
      end
    end
  end
`else
  assign wr_byte = in_data;
`endif

  // Cell RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_slot][wr_idx] <= wr_byte;
    end
  end

  // Load FSM: IDLE waits for a start-of-cell byte, FILL writes offsets 1..52 and commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_state <= LD_IDLE;
      wr_slot  <= '0;
      wr_off   <= 6'd0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= 1'b0;
      if (ld_fire) begin
        if (in_sop) begin
          // A start-of-cell in FILL abandons the partial cell and reuses the slot.
          err_drop <= (ld_state == LD_FILL);
          wr_off   <= 6'd1;
          ld_state <= LD_FILL;
        end else if (ld_state == LD_IDLE) begin
          err_drop <= 1'b1;
        end else if (wr_off == LAST_OFF) begin
          wr_off   <= 6'd0;
          wr_slot  <= next_slot(wr_slot);
          ld_state <= LD_IDLE;
        end else begin
          wr_off <= wr_off + 6'd1;
        end
      end
    end
  end

  // Committed-cell count: commit and transmit start on one edge cancel out.
  always_comb begin
    cnt_next = full_cnt;
    if (commit && !start) begin
      cnt_next = full_cnt + 1'b1;
    end else if (start && !commit) begin
      cnt_next = full_cnt - 1'b1;
    end
  end

  // Count register and its registered availability flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_cnt <= '0;
      clav     <= 1'b0;
    end else begin
      full_cnt <= cnt_next;
      clav     <= (cnt_next != '0);
    end
  end

  // Send FSM: presents octet 0 as soon as a cell is committed, then advances one octet per en=0 edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sd_state <= SD_IDLE;
      rd_slot  <= '0;
      rd_off   <= 6'd0;
      data     <= 8'h00;
      soc      <= 1'b0;
    end else begin
      case (sd_state)
        SD_IDLE: begin
          if (full_cnt != '0) begin
            data     <= mem[rd_slot][0];
            soc      <= 1'b1;
            rd_off   <= 6'd0;
            sd_state <= SD_SEND;
          end
        end
        SD_SEND: begin
          if (consume) begin
            if (rd_off == LAST_OFF) begin
              rd_slot <= rd_next;
              rd_off  <= 6'd0;
              if (full_cnt != '0) begin
                data <= mem[rd_next][0];
                soc  <= 1'b1;
              end else begin
                data     <= 8'h00;
                soc      <= 1'b0;
                sd_state <= SD_IDLE;
              end
            end else begin
              data   <= mem[rd_slot][rd_off + 6'd1];
              soc    <= 1'b0;
              rd_off <= rd_off + 6'd1;
            end
          end
        end
        default: sd_state <= SD_IDLE;
      endcase
    end
  end

endmodule
